// File: rtl/ov7670_dvp_emitter_pkg.sv
// Shared definitions for the OV7670 DVP emitter: FSM state encoding, default
// frame timing and the colour-bar table used by the optional pattern source.
// Also intended for reuse by the capture side and its bench.
package ov7670_dvp_emitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_VBP   = 3'd2,
        ST_ACT   = 3'd3,
        ST_VFP   = 3'd4
    } dvp_state_e;

    localparam int unsigned DEF_IMG_W    = 320;
    localparam int unsigned DEF_IMG_H    = 240;
    localparam int unsigned DEF_VSYNC_LN = 3;
    localparam int unsigned DEF_VBP_LN   = 17;
    localparam int unsigned DEF_VFP_LN   = 10;
    localparam int unsigned DEF_HBLK_CYC = 144;

    localparam int unsigned BAR_CNT = 8;

    // RGB565 colour for each of the eight vertical bars, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ov7670_dvp_emitter_if.sv
// DVP pixel bus plus frame-buffer read port of the emitter.
//   href, vsync, ov7670_data : DVP outputs toward the capture side
//   rE, rAddr                : frame-buffer read request
//   rData                    : RGB565 pixel returned one cycle after rE
// master = emitter, slave = frame buffer / capture side.
interface ov7670_dvp_emitter_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              href;
    logic              vsync;
    logic [7:0]        ov7670_data;
    logic              rE;
    logic [ADDR_W-1:0] rAddr;
    logic [15:0]       rData;

    modport master (output href, vsync, ov7670_data, rE, rAddr, input  rData);
    modport slave  (input  href, vsync, ov7670_data, rE, rAddr, output rData);
endinterface

// File: rtl/ov7670_dvp_emitter_timing_gen.sv
// Frame timing for the DVP emitter: state, line and in-line column counters.
// Ports:
//   ov_pclk, rstn      clock, async active-low reset
//   enable             start / continue frames (sampled in IDLE and last VFP cycle)
//   act_byte_c         current cycle carries an active byte
//   odd_byte_c         current byte index is odd (low byte of the pixel)
//   vs_c               current cycle is inside VSYNC
//   last_act_c         last cycle of the last active line
//   last_vfp_c         last cycle of the frame
//   prefetch_nxt_c     next cycle is a pixel prefetch cycle
//   frame_edge_c, bar_c  (OV7670_EMU_PATTERN_EN only) frame boundary, colour-bar index
module dvp_timing_gen
    import ov7670_dvp_emitter_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned VSYNC_LN = DEF_VSYNC_LN,
    parameter int unsigned VBP_LN   = DEF_VBP_LN,
    parameter int unsigned VFP_LN   = DEF_VFP_LN,
    parameter int unsigned HBLK_CYC = DEF_HBLK_CYC
) (
    input  logic       ov_pclk,
    input  logic       rstn,
    input  logic       enable,
    output logic       act_byte_c,
    output logic       odd_byte_c,
    output logic       vs_c,
    output logic       last_act_c,
    output logic       last_vfp_c,
    output logic       prefetch_nxt_c
`ifdef OV7670_EMU_PATTERN_EN
    ,
    output logic       frame_edge_c,
    output logic [2:0] bar_c
`endif
);

    localparam int unsigned LINE_LEN = 2 * IMG_W + HBLK_CYC;
    localparam int unsigned COL_W    = $clog2(LINE_LEN);
    localparam int unsigned LN_MAX   = max4(VSYNC_LN, VBP_LN, IMG_H, VFP_LN);
    localparam int unsigned LN_W     = $clog2(LN_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0] COL_BLANK  = COL_W'(2 * IMG_W);
    localparam logic [COL_W-1:0] COL_LASTPF = COL_W'(2 * IMG_W - 1);

    dvp_state_e        state_q, state_d;
    logic [LN_W-1:0]   line_q, line_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              col_last, line_last;

    function automatic logic [LN_W-1:0] last_line(input dvp_state_e s);
        logic [LN_W-1:0] l;
        case (s)
            ST_VSYNC: l = LN_W'(VSYNC_LN - 1);
            ST_VBP:   l = LN_W'(VBP_LN - 1);
            ST_ACT:   l = LN_W'(IMG_H - 1);
            ST_VFP:   l = LN_W'(VFP_LN - 1);
            default:  l = '0;
        endcase
        return l;
    endfunction

    // Counter and state registers.
    always_ff @(posedge ov_pclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
        end
    end

    // Next state / counters and strobe decode.
    always_comb begin
        state_d        = state_q;
        line_d         = line_q;
        col_d          = col_q;
        col_last       = (col_q == COL_LAST);
        line_last      = (line_q == last_line(state_q));

        if (state_q == ST_IDLE) begin
            col_d  = '0;
            line_d = '0;
            if (enable) state_d = ST_VSYNC;
        end else if (!col_last) begin
            col_d = col_q + COL_W'(1);
        end else begin
            col_d = '0;
            if (!line_last) begin
                line_d = line_q + LN_W'(1);
            end else begin
                line_d = '0;
                case (state_q)
                    ST_VSYNC: state_d = ST_VBP;
                    ST_VBP:   state_d = ST_ACT;
                    ST_ACT:   state_d = ST_VFP;
                    default:  state_d = enable ? ST_VSYNC : ST_IDLE;
                endcase
            end
        end

        act_byte_c = (state_q == ST_ACT) && (col_q < COL_BLANK);
        odd_byte_c = col_q[0];
        vs_c       = (state_q == ST_VSYNC);
        last_act_c = (state_q == ST_ACT) && line_last && col_last;
        last_vfp_c = (state_q == ST_VFP) && line_last && col_last;

        // Fetch pixel p one cycle before byte 2p: end of the line preceding an
        // active line, and every odd byte except the last one of the line.
        prefetch_nxt_c =
            ((col_d == COL_LAST) &&
             (((state_d == ST_VBP) && (line_d == LN_W'(VBP_LN - 1))) ||
              ((state_d == ST_ACT) && (line_d != LN_W'(IMG_H - 1))))) ||
            ((state_d == ST_ACT) && (col_d < COL_LASTPF) && col_d[0]);

`ifdef OV7670_EMU_PATTERN_EN
        frame_edge_c = (state_q == ST_IDLE) || last_vfp_c;
        bar_c        = 3'((32'(col_q >> 1) * 32'(BAR_CNT)) / 32'(IMG_W));
`endif
    end

endmodule

// File: rtl/ov7670_dvp_emitter.sv
// OV7670 DVP transmit emulator: streams RGB565 frames from a frame buffer as
// vsync/href/8-bit data on ov_pclk, high byte first.
// Ports:
//   ov_pclk, rstn   clock, async active-low reset
//   enable          run frames continuously while high
//   pattern_mode    (OV7670_EMU_PATTERN_EN only) colour bars instead of rData
//   frame_done      1-cycle pulse on the last VFP cycle
//   bus             href/vsync/ov7670_data out, rE/rAddr out, rData in
// Build option: define OV7670_EMU_PATTERN_EN for the built-in colour-bar source.
// rE leads the corresponding high byte on ov7670_data by two cycles: one for the
// frame-buffer read latency and one for the output register.
module ov7670_dvp_emitter
    import ov7670_dvp_emitter_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned VSYNC_LN = DEF_VSYNC_LN,
    parameter int unsigned VBP_LN   = DEF_VBP_LN,
    parameter int unsigned VFP_LN   = DEF_VFP_LN,
    parameter int unsigned HBLK_CYC = DEF_HBLK_CYC
) (
    input  logic                       ov_pclk,
    input  logic                       rstn,
    input  logic                       enable,
`ifdef OV7670_EMU_PATTERN_EN
    input  logic                       pattern_mode,
`endif
    output logic                       frame_done,
    ov7670_dvp_emitter_if.master       bus
);

    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned ADDR_W = $clog2(NPIX);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NPIX - 1);

    logic act_byte_c, odd_byte_c, vs_c, last_act_c, last_vfp_c, prefetch_nxt_c;
    logic pat_use_c;
    logic [15:0] pix_src_c;

    logic              href_q, href_d;
    logic              vsync_q, vsync_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        lo_q, lo_d;
    logic              rE_q, rE_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] rAddr_q, rAddr_d;
    logic              frame_done_q, frame_done_d;

`ifdef OV7670_EMU_PATTERN_EN
    logic       frame_edge_c;
    logic [2:0] bar_c;
    logic       pat_q, pat_d;
`endif

    dvp_timing_gen #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .VSYNC_LN (VSYNC_LN),
        .VBP_LN   (VBP_LN),
        .VFP_LN   (VFP_LN),
        .HBLK_CYC (HBLK_CYC)
    ) u_timing (
        .ov_pclk        (ov_pclk),
        .rstn           (rstn),
        .enable         (enable),
        .act_byte_c     (act_byte_c),
        .odd_byte_c     (odd_byte_c),
        .vs_c           (vs_c),
        .last_act_c     (last_act_c),
        .last_vfp_c     (last_vfp_c),
        .prefetch_nxt_c (prefetch_nxt_c)
`ifdef OV7670_EMU_PATTERN_EN
        ,
        .frame_edge_c   (frame_edge_c),
        .bar_c          (bar_c)
`endif
    );

    // Pixel source: frame buffer, or colour bars latched per frame.
`ifdef OV7670_EMU_PATTERN_EN
    assign pat_use_c = pat_q;
    assign pix_src_c = pat_q ? bar_colour(bar_c) : bus.rData;
`else
    assign pat_use_c = 1'b0;
    assign pix_src_c = bus.rData;
`endif

    // Output, byte mux and pixel-address next values.
    always_comb begin
        href_d       = act_byte_c;
        vsync_d      = vs_c;
        frame_done_d = last_vfp_c;
        data_d       = '0;
        lo_d         = lo_q;
        rd_d         = prefetch_nxt_c;
        rE_d         = prefetch_nxt_c && !pat_use_c;
        rAddr_d      = rAddr_q;

        if (act_byte_c) begin
            if (!odd_byte_c) begin
                data_d = pix_src_c[15:8];
                lo_d   = pix_src_c[7:0];
            end else begin
                data_d = lo_q;
            end
        end

        // Address advances after each pixel fetch and returns to 0 at frame end.
        if (last_act_c) begin
            rAddr_d = '0;
        end else if (rd_q && (rAddr_q != ADDR_MAX)) begin
            rAddr_d = rAddr_q + ADDR_W'(1);
        end
    end

`ifdef OV7670_EMU_PATTERN_EN
    always_comb begin
        pat_d = pat_q;
        if (frame_edge_c) pat_d = pattern_mode;
    end

    always_ff @(posedge ov_pclk or negedge rstn) begin
        if (!rstn) pat_q <= 1'b0;
        else       pat_q <= pat_d;
    end
`endif

    always_ff @(posedge ov_pclk or negedge rstn) begin
        if (!rstn) begin
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            data_q       <= '0;
            lo_q         <= '0;
            rE_q         <= 1'b0;
            rd_q         <= 1'b0;
            rAddr_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            href_q       <= href_d;
            vsync_q      <= vsync_d;
            data_q       <= data_d;
            lo_q         <= lo_d;
            rE_q         <= rE_d;
            rd_q         <= rd_d;
            rAddr_q      <= rAddr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.href        = href_q;
    assign bus.vsync       = vsync_q;
    assign bus.ov7670_data = data_q;
    assign bus.rE          = rE_q;
    assign bus.rAddr       = rAddr_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_ov7670_dvp_emitter.sv
// Directed bench for ov7670_dvp_emitter with a tiny 4x2 frame (10-cycle lines,
// 50-cycle frames). A frame buffer model answers rE one cycle later; each frame
// is captured from the first vsync cycle and checked cycle by cycle.
module tb_ov7670_dvp_emitter;

    localparam int unsigned W     = 4;
    localparam int unsigned H     = 2;
    localparam int unsigned VS    = 1;
    localparam int unsigned VBP   = 1;
    localparam int unsigned VFP   = 1;
    localparam int unsigned HBLK  = 2;
    localparam int unsigned LINE  = 2 * W + HBLK;
    localparam int unsigned FRAME = (VS + VBP + H + VFP) * LINE;
    localparam int unsigned ACT0  = (VS + VBP) * LINE;

    logic ov_pclk;
    logic rstn;
    logic enable;
    logic frame_done;
`ifdef OV7670_EMU_PATTERN_EN
    logic pattern_mode;
`endif

    ov7670_dvp_emitter_if #(.ADDR_W(3)) bus ();

    ov7670_dvp_emitter #(
        .IMG_W    (W),
        .IMG_H    (H),
        .VSYNC_LN (VS),
        .VBP_LN   (VBP),
        .VFP_LN   (VFP),
        .HBLK_CYC (HBLK)
    ) dut (
        .ov_pclk      (ov_pclk),
        .rstn         (rstn),
        .enable       (enable),
`ifdef OV7670_EMU_PATTERN_EN
        .pattern_mode (pattern_mode),
`endif
        .frame_done   (frame_done),
        .bus          (bus)
    );

    logic [15:0] mem  [8] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF00F,
                              16'h8001, 16'h7FFE, 16'hC3C3, 16'h3C5A};
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    int n_tests = 0;
    int n_fail  = 0;

    logic       tr_href [FRAME];
    logic       tr_vs   [FRAME];
    logic       tr_fd   [FRAME];
    logic       tr_re   [FRAME];
    logic [2:0] tr_addr [FRAME];
    logic [7:0] tr_data [FRAME];

    initial ov_pclk = 1'b0;
    always #5 ov_pclk = ~ov_pclk;

    // Frame buffer: data valid exactly one cycle after rE, junk otherwise.
    always @(posedge ov_pclk) begin
        if (bus.rE) bus.rData <= mem[bus.rAddr];
        else        bus.rData <= 16'hDEAD;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, ".href"},  32'(bus.href), 0);
        check({nm, ".vsync"}, 32'(bus.vsync), 0);
        check({nm, ".data"},  32'(bus.ov7670_data), 0);
        check({nm, ".rE"},    32'(bus.rE), 0);
        check({nm, ".rAddr"}, 32'(bus.rAddr), 0);
        check({nm, ".fdone"}, 32'(frame_done), 0);
    endtask

    task automatic wait_vs_rise(input string nm);
        logic prev;
        bit   ok;
        prev = bus.vsync;
        ok   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ov_pclk);
            if (bus.vsync && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = bus.vsync;
        end
        check({nm, ".vsync_rise"}, 32'(ok), 1);
    endtask

    // Record one frame starting at the current (first vsync) sample.
    task automatic capture_frame();
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge ov_pclk);
            tr_href[k] = bus.href;
            tr_vs[k]   = bus.vsync;
            tr_fd[k]   = frame_done;
            tr_re[k]   = bus.rE;
            tr_addr[k] = bus.rAddr;
            tr_data[k] = bus.ov7670_data;
        end
    endtask

    task automatic analyze_frame(input string nm, input bit pat);
        int          nbytes;
        logic [15:0] cap [8];
        for (int k = 0; k < FRAME; k++) begin
            bit          e_href, e_re;
            int          ln, b, p, kk, bb;
            logic [15:0] pix;
            logic [7:0]  e_data;
            e_href = 1'b0;
            e_data = 8'h00;
            if (k >= ACT0 && k < ACT0 + H * LINE) begin
                ln = (k - ACT0) / LINE;
                b  = (k - ACT0) % LINE;
                if (b < 2 * W) begin
                    e_href = 1'b1;
                    p      = ln * W + b / 2;
                    pix    = pat ? bars[(b / 2) * 8 / W] : mem[p];
                    e_data = (b % 2 == 0) ? pix[15:8] : pix[7:0];
                end
            end
            // rE precedes each high byte on the bus by two cycles.
            e_re = 1'b0;
            p    = 0;
            kk   = k + 2;
            if (!pat && kk >= ACT0 && kk < ACT0 + H * LINE) begin
                bb = (kk - ACT0) % LINE;
                if (bb < 2 * W && bb % 2 == 0) begin
                    e_re = 1'b1;
                    p    = ((kk - ACT0) / LINE) * W + bb / 2;
                end
            end
            check($sformatf("%s.href@%0d", nm, k),  32'(tr_href[k]), 32'(e_href));
            check($sformatf("%s.vsync@%0d", nm, k), 32'(tr_vs[k]), 32'(k < VS * LINE));
            check($sformatf("%s.fdone@%0d", nm, k), 32'(tr_fd[k]), 32'(k == FRAME - 1));
            check($sformatf("%s.data@%0d", nm, k),  32'(tr_data[k]), 32'(e_data));
            check($sformatf("%s.rE@%0d", nm, k),    32'(tr_re[k]), 32'(e_re));
            if (e_re) check($sformatf("%s.rAddr@%0d", nm, k), 32'(tr_addr[k]), 32'(p));
        end
        check({nm, ".rAddr_start"}, 32'(tr_addr[0]), 0);
        check({nm, ".rAddr_end"},   32'(tr_addr[FRAME-1]), 0);

        // Reassemble pixels as a capture block would and compare to the source.
        nbytes = 0;
        for (int i = 0; i < 8; i++) cap[i] = 16'h0;
        for (int k = 0; k < FRAME; k++) begin
            if (tr_href[k]) begin
                if (nbytes < 16) begin
                    if (nbytes % 2 == 0) cap[nbytes/2][15:8] = tr_data[k];
                    else                 cap[nbytes/2][7:0]  = tr_data[k];
                end
                nbytes++;
            end
        end
        check({nm, ".nbytes"}, 32'(nbytes), 16);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.pix%0d", nm, i), 32'(cap[i]),
                  32'(pat ? bars[(i % W) * 8 / W] : mem[i]));
        end
    endtask

    initial begin
        int cnt_vs, cnt_href, cnt_re, cnt_data;
        bit seen;
        rstn   = 1'b0;
        enable = 1'b0;
`ifdef OV7670_EMU_PATTERN_EN
        pattern_mode = 1'b0;
`endif
        repeat (3) @(negedge ov_pclk);
        check_outputs_zero("reset");

        rstn = 1'b1;
        repeat (5) @(negedge ov_pclk);
        check_outputs_zero("idle");

        // Two back-to-back frames from memory.
        enable = 1'b1;
        wait_vs_rise("f1");
        capture_frame();
        analyze_frame("f1", 1'b0);
        wait_vs_rise("f2");
        capture_frame();
        analyze_frame("f2", 1'b0);

        // Drop enable mid-ACT: frame completes, then the emitter idles.
        wait_vs_rise("f3");
        repeat (25) @(negedge ov_pclk);
        enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ov_pclk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("drop.frame_done", 32'(seen), 1);
        cnt_vs = 0; cnt_href = 0; cnt_re = 0; cnt_data = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge ov_pclk);
            cnt_vs   += int'(bus.vsync);
            cnt_href += int'(bus.href);
            cnt_re   += int'(bus.rE);
            cnt_data += int'(bus.ov7670_data != 8'h00);
        end
        check("drop.vsync_cnt", 32'(cnt_vs), 0);
        check("drop.href_cnt",  32'(cnt_href), 0);
        check("drop.rE_cnt",    32'(cnt_re), 0);
        check("drop.data_cnt",  32'(cnt_data), 0);
        check("drop.rAddr",     32'(bus.rAddr), 0);
        enable = 1'b1;
        wait_vs_rise("f4");
        capture_frame();
        analyze_frame("f4", 1'b0);

        // Reset in the middle of an active line.
        wait_vs_rise("f5");
        repeat (23) @(negedge ov_pclk);
        check("mid.href_before", 32'(bus.href), 1);
        rstn = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        @(negedge ov_pclk);
        check_outputs_zero("rst_edge");
        rstn = 1'b1;
        wait_vs_rise("f6");
        capture_frame();
        analyze_frame("f6", 1'b0);

`ifdef OV7670_EMU_PATTERN_EN
        // Pattern mode takes effect at the next frame boundary.
        pattern_mode = 1'b1;
        wait_vs_rise("f7");
        wait_vs_rise("f8");
        capture_frame();
        analyze_frame("pat", 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
